// File: rtl/ins_mem_pkg.sv
// Shared constants for the multiport instruction memory.
// Port limits, read latency and default geometry.
package ins_mem_pkg;
   localparam int MAX_PORTS  = 8;
   localparam int RD_LATENCY = 1;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DEPTH  = 256;
   localparam int PORT_IDX_W = $clog2(MAX_PORTS);
endpackage

// File: rtl/ins_mem_multiport_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Search starts at the port after the last winner.
module rr_arbiter
   import ins_mem_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last_q;
   logic [PW-1:0] win;
   logic          found;
   int            idx;

   // pick first requester after last_q, wrapping
   always_comb begin
      grant = '0;
      win   = last_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_q) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            win        = PW'(idx);
            found      = 1'b1;
         end
      end
   end

   // pointer moves only on a grant; reset makes port 0 win first
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         last_q <= PW'(N - 1);
      else if (advance)
         last_q <= win;
   end
endmodule

// File: rtl/ins_mem_multiport.sv
// Instruction memory with one write port and N arbitrated read ports.
// Writes beat reads; one granted read returns data one cycle later.
module ins_mem_multiport
   import ins_mem_pkg::*;
#(
   parameter int    WIDTH      = DEF_WIDTH,
   parameter int    DEPTH      = DEF_DEPTH,
   parameter int    ADDR_WIDTH = $clog2(DEPTH),
   parameter int    NUM_PORTS  = 4,
   parameter int    MEM_INIT   = 0,
   parameter string INIT_FILE  = "ins_mem.txt"
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            writeEn,
   input  logic [ADDR_WIDTH-1:0]           wrAddr,
   input  logic [WIDTH-1:0]                dataIn,
   input  logic [NUM_PORTS-1:0]            rdReq,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rdAddr,
   output logic [NUM_PORTS-1:0]            rdAck,
   output logic [NUM_PORTS-1:0]            rdValid,
   output logic [WIDTH-1:0]                dataOut
);
   logic [WIDTH-1:0]      mem [DEPTH];
   logic [NUM_PORTS-1:0]  req_eff;
   logic [NUM_PORTS-1:0]  grant;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [PORT_IDX_W-1:0] sel_port;
   logic [PORT_IDX_W-1:0] port_q;
   logic                  valid_q;
   logic [WIDTH-1:0]      dout_q;

   assign req_eff = writeEn ? '0 : rdReq;

   rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req_eff),
      .advance (|grant),
      .grant   (grant)
   );

   assign rdAck = reset_n ? grant : '0;

   // route the winning port's address and index
   always_comb begin
      sel_port = '0;
      sel_addr = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            sel_port = PORT_IDX_W'(i);
            sel_addr = rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // program-load write; out-of-range addresses are dropped
   always_ff @(posedge clock) begin
      if (writeEn && (int'(wrAddr) < DEPTH))
         mem[wrAddr] <= dataIn;
   end

   // capture grant and synchronous read; reset discards in-flight read
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         port_q  <= '0;
         dout_q  <= '0;
      end else begin
         valid_q <= |grant;
         if (|grant) begin
            port_q <= sel_port;
            if (int'(sel_addr) < DEPTH)
               dout_q <= mem[sel_addr];
            else
               dout_q <= '0;
         end
      end
   end

   // decode the in-flight port into a one-hot valid
   always_comb begin
      rdValid = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         rdValid[i] = valid_q && (port_q == PORT_IDX_W'(i));
   end

   assign dataOut = dout_q;
endmodule

// File: tb/tb_ins_mem_multiport.sv
// Randomized scoreboard bench for ins_mem_multiport.
// Model: plain array memory plus a "next pending port after last winner" rule.
module tb_ins_mem_multiport;
   localparam int W  = 8;
   localparam int D  = 200;
   localparam int AW = 8;
   localparam int NP = 4;

   logic             clock = 1'b0;
   logic             reset_n = 1'b1;
   logic             writeEn = 1'b0;
   logic [AW-1:0]    wrAddr = '0;
   logic [W-1:0]     dataIn = '0;
   logic [NP-1:0]    rdReq = '0;
   logic [NP*AW-1:0] rdAddr = '0;
   logic [NP-1:0]    rdAck;
   logic [NP-1:0]    rdValid;
   logic [W-1:0]     dataOut;

   logic             rq1 = 1'b0;
   logic [AW-1:0]    ra1 = '0;
   logic             ack1;
   logic             val1;
   logic [W-1:0]     dout1;

   always #5 clock = ~clock;

   ins_mem_multiport #(
      .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_PORTS(NP)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .writeEn(writeEn), .wrAddr(wrAddr), .dataIn(dataIn),
      .rdReq(rdReq), .rdAddr(rdAddr),
      .rdAck(rdAck), .rdValid(rdValid), .dataOut(dataOut)
   );

   ins_mem_multiport #(
      .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_PORTS(1)
   ) dut1 (
      .clock(clock), .reset_n(reset_n),
      .writeEn(writeEn), .wrAddr(wrAddr), .dataIn(dataIn),
      .rdReq(rq1), .rdAddr(ra1),
      .rdAck(ack1), .rdValid(val1), .dataOut(dout1)
   );

   typedef struct {
      int           due;
      int           port;
      logic [W-1:0] data;
   } exp_t;

   exp_t          q[$];
   logic [W-1:0]  mdl [D];
   int            ptr = NP - 1;
   bit            pend [NP];
   logic [AW-1:0] paddr [NP];
   logic [W-1:0]  last_data = '0;
   int            last_g = -1;
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] rd_model(input int a);
      return (a < D) ? mdl[a] : '0;
   endfunction

   // monitor: outputs are registered, so sample on the falling edge
   always @(negedge clock) begin
      logic [NP-1:0] ev;
      if (q.size() > 0 && q[0].due == cyc) begin
         ev = '0;
         ev[q[0].port] = 1'b1;
         last_data = q[0].data;
         chk("rdValid", 32'(rdValid), 32'(ev));
         chk("dataOut", 32'(dataOut), 32'(q[0].data));
         void'(q.pop_front());
      end else begin
         chk("rdValid_idle", 32'(rdValid), 32'h0);
         chk("dataOut_hold", 32'(dataOut), 32'(last_data));
      end
   end

   // one cycle of stimulus; expected ack and read data come from the model
   task automatic step(input bit we, input int wa, input logic [W-1:0] wd);
      int            g;
      logic [NP-1:0] eg;
      @(negedge clock);
      writeEn = we;
      wrAddr  = AW'(wa);
      dataIn  = wd;
      for (int i = 0; i < NP; i++) begin
         rdReq[i] = pend[i];
         rdAddr[i*AW +: AW] = paddr[i];
      end
      #1;
      g = -1;
      if (!we)
         for (int k = 1; k <= NP; k++)
            if (g < 0 && pend[(ptr + k) % NP]) g = (ptr + k) % NP;
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("rdAck", 32'(rdAck), 32'(eg));
      last_g = g;
      if (g >= 0) begin
         q.push_back('{cyc + 1, g, rd_model(int'(paddr[g]))});
         ptr = g;
         pend[g] = 1'b0;
      end
      if (we && wa < D) mdl[wa] = wd;
   endtask

   // reset right after an edge, so anything granted there is discarded
   task automatic do_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      q.delete();
      last_data = '0;
      ptr = NP - 1;
      for (int i = 0; i < NP; i++) pend[i] = 1'b0;
      writeEn = 1'b0;
      rdReq = '1;
      @(negedge clock);
      #1;
      chk("rdAck_in_reset", 32'(rdAck), 32'h0);
      rdReq = '0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [AW-1:0] pa;
      for (int i = 0; i < NP; i++) begin
         pend[i] = 1'b0;
         paddr[i] = '0;
      end
      do_reset();

      for (int a = 0; a < D; a++) step(1'b1, a, W'($urandom));

      // first read after reset goes to port 0 immediately
      step(1'b1, 5, 8'h3C);
      do_reset();
      pend[0] = 1'b1;
      paddr[0] = 8'd5;
      step(1'b0, 0, '0);
      chk("first_grant_port0", 32'(last_g), 32'd0);
      step(1'b0, 0, '0);

      // all ports requesting continuously
      do_reset();
      for (int i = 0; i < NP; i++) begin
         pend[i] = 1'b1;
         paddr[i] = AW'($urandom_range(0, D - 1));
      end
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 0, '0);
         chk("rr_order", 32'(last_g), 32'(k % NP));
         if (last_g >= 0) begin
            pend[last_g] = 1'b1;
            paddr[last_g] = AW'($urandom_range(0, D - 1));
         end
      end

      // write blocks reads; the following read sees new data
      for (int i = 0; i < NP; i++) pend[i] = 1'b0;
      pend[1] = 1'b1;
      paddr[1] = 8'd7;
      pend[2] = 1'b1;
      paddr[2] = 8'd20;
      step(1'b1, 7, 8'hA5);
      step(1'b0, 0, '0);
      chk("after_write_port1", 32'(last_g), 32'd1);
      step(1'b0, 0, '0);

      // out-of-range write and read, then last valid address
      step(1'b1, 210, 8'h77);
      pend[0] = 1'b1;
      paddr[0] = 8'd210;
      step(1'b0, 0, '0);
      pend[0] = 1'b1;
      paddr[0] = 8'd199;
      step(1'b0, 0, '0);
      step(1'b0, 0, '0);

      // reset with a read in flight; memory survives, port 0 first again
      pend[3] = 1'b1;
      paddr[3] = 8'd9;
      step(1'b0, 0, '0);
      do_reset();
      for (int i = 0; i < NP; i++) begin
         pend[i] = 1'b1;
         paddr[i] = AW'($urandom_range(0, D - 1));
      end
      step(1'b0, 0, '0);
      chk("post_reset_port0", 32'(last_g), 32'd0);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NP; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               paddr[i] = AW'($urandom_range(0, D + 30));
            end
         if ($urandom_range(0, 4) == 0)
            step(1'b1, int'($urandom_range(0, D + 20)), W'($urandom));
         else
            step(1'b0, 0, '0);
      end
      for (int i = 0; i < NP; i++) pend[i] = 1'b0;
      step(1'b0, 0, '0);
      step(1'b0, 0, '0);

      // single-port build: ack every cycle, valid from the second
      pa = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         writeEn = 1'b0;
         rdReq = '0;
         if (k > 0) begin
            chk("np1_valid", 32'(val1), 32'd1);
            chk("np1_data", 32'(dout1), 32'(rd_model(int'(pa))));
         end else begin
            chk("np1_valid_first", 32'(val1), 32'd0);
         end
         pa = AW'($urandom_range(0, D - 1));
         rq1 = 1'b1;
         ra1 = pa;
         #1;
         chk("np1_ack", 32'(ack1), 32'd1);
      end
      @(negedge clock);
      rq1 = 1'b0;

      step(1'b0, 0, '0);
      step(1'b0, 0, '0);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ins_mem_multiport.md
INS_MEM_MULTIPORT -- requirements
Module: ins_mem_multiport

Interface
REQ-001 Parameter WIDTH, default 8: instruction word width in bits.
REQ-002 Parameter DEPTH, default 256: number of words; need not be a power of two.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH): address width.
REQ-004 Parameter NUM_PORTS, default 4: number of core read ports, range 1..8.
REQ-005 Parameter MEM_INIT, default 0: when 1, the array SHALL be preloaded in simulation from INIT_FILE using binary format.
REQ-006 Parameter INIT_FILE, default "ins_mem.txt": path of the preload file.
REQ-007 Port clock, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-008 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-009 Port writeEn, input, 1: program-load write strobe.
REQ-010 Port wrAddr, input, ADDR_WIDTH: write address.
REQ-011 Port dataIn, input, WIDTH: write data.
REQ-012 Port rdReq, input, NUM_PORTS: per-port read request, held high until acknowledged.
REQ-013 Port rdAddr, input, NUM_PORTS*ADDR_WIDTH: per-port read address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 Port rdAck, output, NUM_PORTS: one-hot grant, asserted in the cycle the request is accepted.
REQ-015 Port rdValid, output, NUM_PORTS: one-hot flag marking the cycle in which dataOut is valid for that port.
REQ-016 Port dataOut, output, WIDTH: shared read data bus.

Function
REQ-017 The block SHALL serve at most one operation per cycle: either one write or one granted read.
REQ-018 When writeEn=1, the write SHALL take priority, rdAck SHALL be all-zero that cycle, and memory[wrAddr] SHALL be updated at the clock edge.
REQ-019 When writeEn=0 and rdReq is non-zero, exactly one port SHALL be acknowledged, chosen by round-robin starting at the port after the last granted port, wrapping from NUM_PORTS-1 to 0.
REQ-020 The round-robin pointer SHALL advance only on a grant; it SHALL hold on idle cycles and on write cycles.
REQ-021 rdAck SHALL be combinational from rdReq, writeEn and the pointer; the requester SHALL drop or change its request only after the edge at which rdAck was high.
REQ-022 On a grant, the address and the port index SHALL be registered; in the following cycle rdValid[port]=1 and dataOut=memory[registered address], giving a latency of 1 cycle from the ack edge.
REQ-023 Back-to-back grants SHALL sustain one read per cycle with no bubble.
REQ-024 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-025 When no read is in flight, rdValid SHALL be 0 and dataOut SHALL hold its last value.
REQ-026 A write with wrAddr >= DEPTH SHALL be ignored.
REQ-027 A read with address >= DEPTH SHALL be acknowledged normally and SHALL return all-zero data.
REQ-028 An unrequested port SHALL never receive rdAck or rdValid.

Reset
REQ-029 While reset_n=0, rdValid SHALL be 0, dataOut 0, the round-robin pointer NUM_PORTS-1 (so port 0 wins first), and the in-flight register empty.
REQ-030 rdAck SHALL be forced to 0 while reset_n=0.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 A read in flight when reset asserts SHALL be discarded, with no rdValid after release.
REQ-033 The first grant SHALL be possible in the first cycle after reset_n deasserts.

Structure
REQ-034 A shared package ins_mem_pkg SHALL hold MAX_PORTS=8, the read-latency constant RD_LATENCY=1, and the default WIDTH and DEPTH values.
REQ-035 Arbitration SHALL live in a sub-module rr_arbiter (parameter N; inputs req and advance; output one-hot grant), instantiated once.
REQ-036 The memory array SHALL be inferable as a single-port synchronous RAM.

Verification
REQ-037 Reset, then port 0 reads address 5 holding 0x3C -> rdAck[0] in cycle 0, rdValid[0]=1 and dataOut=0x3C in cycle 1.
REQ-038 All 4 ports request continuously -> grants in order 0,1,2,3,0, with one rdValid per cycle and each dataOut matching its port's address.
REQ-039 writeEn=1 to address 7 with 0xA5 while ports 1 and 2 request -> no ack that cycle; the next cycle grants port 1, and a read of address 7 returns 0xA5.
REQ-040 DEPTH=200; write to address 210, then read address 210 -> the write has no effect and dataOut=0x00; a read of address 199 returns stored data.
REQ-041 Assert reset_n=0 in the cycle after a grant -> no rdValid; memory is retained; after release, port 0 has priority.
REQ-042 NUM_PORTS=1 build: continuous requests -> an ack every cycle and rdValid every cycle after the first.
